// File: rtl/ul4_logic_unit.sv
// Registered bitwise logic slice (AND/OR/XOR/NOT-A); one-cycle latency, en=0 holds the result.
// Define UL4_ZERO_FLAG_EN to add a registered zero flag that tracks Out.
module ul4_logic_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] Out,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       S
`ifdef UL4_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] out_d, out_q;

  always_comb begin
    res = A & B;
    case (S)
      2'b00:   res = A & B;
      2'b01:   res = A | B;
      2'b10:   res = A ^ B;
      2'b11:   res = ~A;
      default: res = A & B;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (en) out_d = res;
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign Out = out_q;

`ifdef UL4_ZERO_FLAG_EN
  logic zero_d, zero_q;

  // Flag is derived from the same load decision as Out so the two never diverge.
  always_comb begin
    zero_d = zero_q;
    if (en) zero_d = (res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) zero_q <= 1'b1;
    else     zero_q <= zero_d;
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_ul4_logic_unit.sv
// Scoreboard bench for ul4_logic_unit: driver pushes model results, monitor compares after each edge.
module tb_ul4_logic_unit;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] Out;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   S;
`ifdef UL4_ZERO_FLAG_EN
  logic         zero;
`endif

  ul4_logic_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .Out (Out),
    .A   (A),
    .B   (B),
    .S   (S)
`ifdef UL4_ZERO_FLAG_EN
    ,
    .zero(zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    string        nm;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_out = '0;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] s);
    case (s)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Applies one cycle of stimulus; exp >= 0 overrides the model with a hand-derived value.
  task automatic step(input logic r, input logic e, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [1:0] s, input int exp, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; A = a; B = b; S = s;
    if (r)      model_out = '0;
    else if (e) model_out = ref_op(a, b, s);
    x.out = (exp >= 0) ? W'(exp) : model_out;
    x.nm  = nm;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (Out !== x.out) begin
          errors++;
          $display("FAIL %s out: got %b expected %b at %0t", x.nm, Out, x.out, $time);
        end
`ifdef UL4_ZERO_FLAG_EN
        checks++;
        if (zero !== (x.out == '0)) begin
          errors++;
          $display("FAIL %s zero: got %b expected %b at %0t", x.nm, zero, (x.out == '0), $time);
        end
`endif
      end
    end
  end

  initial begin : driver
    rst = 1'b1; en = 1'b0; A = '0; B = '0; S = '0;

    step(1, 1, 4'hF, 4'hF, 2'b01, 0, "reset0");
    step(1, 1, 4'hF, 4'hF, 2'b01, 0, "reset1");
    step(0, 1, 4'hF, 4'hF, 2'b01, 4'hF, "reset_release");

    step(0, 1, 4'b1100, 4'b1010, 2'b00, 4'b1000, "sweep_and");
    step(0, 1, 4'b1100, 4'b1010, 2'b01, 4'b1110, "sweep_or");
    step(0, 1, 4'b1100, 4'b1010, 2'b10, 4'b0110, "sweep_xor");
    step(0, 1, 4'b1100, 4'b1010, 2'b11, 4'b0011, "sweep_not");

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 4; s++)
          step(0, 1, W'(a), W'(b), 2'(s), -1, "exhaustive");

    step(0, 1, 4'b0101, 4'b0011, 2'b10, 4'b0110, "hold_load");
    step(0, 0, 4'b1111, 4'b0000, 2'b01, 4'b0110, "hold0");
    step(0, 0, 4'b0000, 4'b1001, 2'b11, 4'b0110, "hold1");
    step(0, 0, 4'b1011, 4'b0110, 2'b00, 4'b0110, "hold2");
    step(0, 1, 4'b0111, 4'b1110, 2'b01, 4'b1111, "hold_release");

    step(0, 1, 4'b1010, 4'b0101, 2'b00, 4'b0000, "zero_and");
    step(0, 1, 4'b1111, 4'b0110, 2'b11, 4'b0000, "zero_not");
    step(0, 1, 4'b0001, 4'b0000, 2'b01, 4'b0001, "zero_clear");

    step(0, 1, 4'b1100, 4'b1010, 2'b01, 4'b1110, "prio_pre");
    step(1, 1, 4'b1111, 4'b0000, 2'b01, 0, "prio_rst");
    step(0, 1, 4'b0011, 4'b0101, 2'b10, 4'b0110, "prio_resume");
    step(0, 0, 4'b1111, 4'b1111, 2'b00, 4'b0110, "prio_hold");

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), W'($urandom),
           W'($urandom), 2'($urandom), -1, "random");

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
